// File: rtl/ym3438_pcm_pkg.sv
// Shared defaults, FSM type and DAC conversion helper for the OPN2 DAC-to-PCM
// frame accumulator.
package ym3438_pcm_pkg;

  localparam int DEF_SLOTS = 24;
  localparam int DEF_SHIFT = 1;
  localparam int DEF_OUT_W = 16;

  typedef enum logic {
    ST_SEEK  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Offset binary to two's complement: flipping the MSB maps 0x100 to zero.
  function automatic logic signed [8:0] dac_to_signed(input logic [8:0] v);
    return {~v[8], v[7:0]};
  endfunction

  // Signed accumulator width that holds SLOTS full-scale 9-bit values.
  function automatic int acc_width(input int slots);
    return $clog2(slots * 256) + 1;
  endfunction

endpackage

// File: rtl/ym3438_pcm_lane.sv
// One stereo lane: converts each DAC slot value, integrates it over the frame,
// then shifts, saturates and registers the completed frame sum.
module ym3438_pcm_lane
  import ym3438_pcm_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_load,
  input  logic                    i_add,
  input  logic                    i_emit,
  input  logic [8:0]              i_dac,
  output logic signed [OUT_W-1:0] o_pcm
);

  localparam int ACC_W = acc_width(SLOTS);
  localparam int EXT_W = ACC_W + SHIFT + OUT_W;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [8:0]       w_val;
  logic signed [ACC_W-1:0] w_val_ext;
  logic signed [EXT_W-1:0] w_shifted;
  logic signed [OUT_W-1:0] w_sat;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [OUT_W-1:0] r_pcm;

  assign w_val     = dac_to_signed(i_dac);
  assign w_val_ext = {{(ACC_W-9){w_val[8]}}, w_val};

  // Sign-extend far enough that the shift can never wrap before the clamp.
  assign w_shifted = {{(EXT_W-ACC_W){r_acc[ACC_W-1]}}, r_acc} <<< SHIFT;

  always_comb begin
    if (w_shifted > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      w_sat = w_shifted[OUT_W-1:0];
    end
  end

  // Emit samples the sum of the frame just ended while load restarts it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= '0;
      r_pcm <= '0;
    end else begin
      if (i_load) begin
        r_acc <= w_val_ext;
      end else if (i_add) begin
        r_acc <= r_acc + w_val_ext;
      end
      if (i_emit) begin
        r_pcm <= w_sat;
      end
    end
  end

  assign o_pcm = r_pcm;

endmodule

// File: rtl/ym3438_pcm_accum.sv
// Frame integrator for the OPN2 MOL/MOR DAC stream: aligns on sample_sync,
// sums SLOTS values per lane and presents one stereo PCM sample per frame.
module ym3438_pcm_accum
  import ym3438_pcm_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                    MCLK,
  input  logic                    reset,
  input  logic                    phi_en,
  input  logic                    sample_sync,
  input  logic [8:0]              mol,
  input  logic [8:0]              mor,
  output logic signed [OUT_W-1:0] pcm_l,
  output logic signed [OUT_W-1:0] pcm_r,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overrun,
  output logic                    frame_err
);

  localparam int               CNT_W    = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_full;
  logic             w_load;
  logic             w_add;
  logic             w_emit;
  logic             w_ferr;
  logic             w_accept;
  logic             r_valid;
  logic             r_overrun;
  logic             r_frame_err;

  assign w_full = (r_cnt == CNT_FULL);

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_state <= ST_SEEK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_SEEK:  if (phi_en && sample_sync) w_state_nx = ST_ACCUM;
      ST_ACCUM: if (phi_en && !sample_sync && w_full) w_state_nx = ST_SEEK;
      default:  w_state_nx = ST_SEEK;
    endcase
  end

  // A sync on a full count completes the frame; any other sync or an extra
  // slot past a full count means we lost alignment with the core.
  always_comb begin
    w_load   = 1'b0;
    w_add    = 1'b0;
    w_emit   = 1'b0;
    w_ferr   = 1'b0;
    w_cnt_nx = r_cnt;
    if (phi_en) begin
      case (r_state)
        ST_SEEK: begin
          if (sample_sync) begin
            w_load   = 1'b1;
            w_cnt_nx = CNT_ONE;
          end
        end
        ST_ACCUM: begin
          if (sample_sync) begin
            w_load   = 1'b1;
            w_emit   = w_full;
            w_ferr   = !w_full;
            w_cnt_nx = CNT_ONE;
          end else if (w_full) begin
            w_ferr   = 1'b1;
            w_cnt_nx = '0;
          end else begin
            w_add    = 1'b1;
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_cnt_nx = '0;
        end
      endcase
    end
  end

  // Stream: a sample transfers on any edge where pcm_valid & pcm_ready; the
  // held sample stays stable until then, valid never depends on ready
  // combinationally, and a new completion replaces an unaccepted sample.
  assign w_accept = r_valid & pcm_ready;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_emit & r_valid & ~pcm_ready;
      if (w_emit) begin
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign pcm_valid = r_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  ym3438_pcm_lane #(
    .SLOTS(SLOTS),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_lane_l (
    .i_clk  (MCLK),
    .i_reset(reset),
    .i_load (w_load),
    .i_add  (w_add),
    .i_emit (w_emit),
    .i_dac  (mol),
    .o_pcm  (pcm_l)
  );

  ym3438_pcm_lane #(
    .SLOTS(SLOTS),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_lane_r (
    .i_clk  (MCLK),
    .i_reset(reset),
    .i_load (w_load),
    .i_add  (w_add),
    .i_emit (w_emit),
    .i_dac  (mor),
    .o_pcm  (pcm_r)
  );

endmodule

// File: tb/tb_ym3438_pcm_accum.sv
// Bench for ym3438_pcm_accum: two instances (SHIFT=1 and SHIFT=3) share one
// randomized DAC stream and are compared every cycle against a frame-level model.
module tb_ym3438_pcm_accum;

  localparam int SLOTS = 24;

  logic               clk = 1'b0;
  logic               reset;
  logic               phi_en;
  logic               sample_sync;
  logic               pcm_ready;
  logic [8:0]         mol;
  logic [8:0]         mor;
  logic signed [15:0] pcm_l1, pcm_r1, pcm_l3, pcm_r3;
  logic               valid1, valid3, ovr1, ovr3, ferr1, ferr3;

  ym3438_pcm_accum #(.SLOTS(SLOTS), .SHIFT(1), .OUT_W(16)) dut1 (
    .MCLK(clk), .reset(reset), .phi_en(phi_en), .sample_sync(sample_sync),
    .mol(mol), .mor(mor), .pcm_l(pcm_l1), .pcm_r(pcm_r1),
    .pcm_valid(valid1), .pcm_ready(pcm_ready), .overrun(ovr1), .frame_err(ferr1)
  );

  ym3438_pcm_accum #(.SLOTS(SLOTS), .SHIFT(3), .OUT_W(16)) dut3 (
    .MCLK(clk), .reset(reset), .phi_en(phi_en), .sample_sync(sample_sync),
    .mol(mol), .mor(mor), .pcm_l(pcm_l3), .pcm_r(pcm_r3),
    .pcm_valid(valid3), .pcm_ready(pcm_ready), .overrun(ovr3), .frame_err(ferr3)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model state and scoreboard
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          rdy_mode = 0;
  bit          m_in_frame;
  int          m_ql[$];
  int          m_qr[$];
  logic        m_valid, m_ovr, m_ferr;
  logic [63:0] exp_q[$];

  function automatic int dac_value(input logic [8:0] v);
    return int'(v) - 256;
  endfunction

  function automatic logic [15:0] sat16(input int x);
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic model_clear();
    m_in_frame = 1'b0;
    m_ql.delete();
    m_qr.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic s, input logic [8:0] l,
                            input logic [8:0] r, input logic rdy);
    int sl, sr;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    if (m_valid && rdy) begin
      void'(exp_q.pop_front());
      m_valid = 1'b0;
    end
    if (p) begin
      if (s) begin
        if (m_in_frame && m_ql.size() == SLOTS) begin
          sl = 0;
          sr = 0;
          foreach (m_ql[i]) begin
            sl += m_ql[i];
            sr += m_qr[i];
          end
          if (m_valid) begin
            m_ovr = 1'b1;
            void'(exp_q.pop_back());
          end
          exp_q.push_back({sat16(sl * 2), sat16(sr * 2), sat16(sl * 8), sat16(sr * 8)});
          m_valid = 1'b1;
        end else if (m_in_frame) begin
          m_ferr = 1'b1;
        end
        m_ql.delete();
        m_qr.delete();
        m_ql.push_back(dac_value(l));
        m_qr.push_back(dac_value(r));
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        if (m_ql.size() < SLOTS) begin
          m_ql.push_back(dac_value(l));
          m_qr.push_back(dac_value(r));
        end else begin
          m_ferr = 1'b1;
          m_in_frame = 1'b0;
          m_ql.delete();
          m_qr.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [63:0] e;
    chk("pcm_valid_s1", 16'(valid1), 16'(m_valid));
    chk("pcm_valid_s3", 16'(valid3), 16'(m_valid));
    chk("overrun_s1", 16'(ovr1), 16'(m_ovr));
    chk("overrun_s3", 16'(ovr3), 16'(m_ovr));
    chk("frame_err_s1", 16'(ferr1), 16'(m_ferr));
    chk("frame_err_s3", 16'(ferr3), 16'(m_ferr));
    if (m_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("pcm_l_s1", pcm_l1, e[63:48]);
      chk("pcm_r_s1", pcm_r1, e[47:32]);
      chk("pcm_l_s3", pcm_l3, e[31:16]);
      chk("pcm_r_s3", pcm_r3, e[15:0]);
    end
  endtask

  // Driver tasks
  task automatic step(input logic p, input logic s, input logic [8:0] l, input logic [8:0] r);
    logic rdy;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'b0;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = p & s;
    endcase
    phi_en      = p;
    sample_sync = s;
    mol         = l;
    mor         = r;
    pcm_ready   = rdy;
    model_step(p, s, l, r, rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    phi_en      = 1'b1;
    sample_sync = 1'b1;
    pcm_ready   = 1'b0;
    mol         = 9'h1ff;
    mor         = 9'h000;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_pcm_l_s1", pcm_l1, 16'h0000);
    chk("rst_pcm_r_s1", pcm_r1, 16'h0000);
    chk("rst_pcm_l_s3", pcm_l3, 16'h0000);
    chk("rst_pcm_r_s3", pcm_r3, 16'h0000);
    chk("rst_valid", 16'(valid1), 16'h0000);
    chk("rst_overrun", 16'(ovr1), 16'h0000);
    chk("rst_frame_err", 16'(ferr1), 16'h0000);
    reset = 1'b0;
  endtask

  // mode 0 silence, 1 full-scale +/-, 2 random, 3 random extremes
  task automatic run_slots(input int n, input int mode, input bit first_sync, input bit gaps);
    logic [8:0] l, r;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom));
      end
      case (mode)
        0: begin l = 9'h100; r = 9'h100; end
        1: begin l = 9'h1ff; r = 9'h000; end
        2: begin l = 9'($urandom); r = 9'($urandom); end
        default: begin
          l = ($urandom_range(0, 3) != 0) ? 9'h1ff : 9'h000;
          r = ($urandom_range(0, 3) != 0) ? 9'h000 : 9'h1ff;
        end
      endcase
      step(1'b1, first_sync && (i == 0), l, r);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    phi_en = 1'b0;
    sample_sync = 1'b0;
    pcm_ready = 1'b0;
    mol = 9'h100;
    mor = 9'h100;
    model_clear();
    do_reset();

    // Silence frames with an always-ready consumer
    rdy_mode = 0;
    repeat (3) run_slots(SLOTS, 0, 1'b1, 1'b0);
    run_slots(1, 1, 1'b1, 1'b0);
    chk("silence_pcm_l", pcm_l1, 16'h0000);
    chk("silence_valid", 16'(valid1), 16'h0001);
    run_slots(SLOTS - 1, 1, 1'b0, 1'b0);

    // Full-scale frame: +255 and -256 over 24 slots
    run_slots(1, 2, 1'b1, 1'b1);
    chk("full_l_s1", pcm_l1, 16'(12240));
    chk("full_r_s1", pcm_r1, 16'(-12288));
    chk("sat_l_s3", pcm_l3, 16'h7fff);
    chk("sat_r_s3", pcm_r3, 16'h8000);
    run_slots(SLOTS - 1, 2, 1'b0, 1'b1);

    // Short frame, then a normal frame, then a 25-slot overrun of the count
    run_slots(20, 2, 1'b1, 1'b1);
    run_slots(1, 2, 1'b1, 1'b1);
    chk("short_frame_err", 16'(ferr1), 16'h0001);
    chk("short_no_valid", 16'(valid1), 16'h0000);
    run_slots(SLOTS - 1, 2, 1'b0, 1'b1);
    run_slots(1, 2, 1'b1, 1'b1);
    run_slots(SLOTS, 2, 1'b0, 1'b1);
    chk("long_frame_err", 16'(ferr1), 16'h0001);
    run_slots(SLOTS, 2, 1'b1, 1'b1);
    run_slots(SLOTS, 2, 1'b1, 1'b1);
    run_slots(1, 2, 1'b1, 1'b1);

    // Consumer stalled across two completions
    rdy_mode = 1;
    run_slots(SLOTS - 1, 3, 1'b0, 1'b1);
    run_slots(SLOTS, 3, 1'b1, 1'b1);
    run_slots(1, 3, 1'b1, 1'b1);
    chk("overrun_pulse", 16'(ovr1), 16'h0001);
    run_slots(SLOTS - 1, 3, 1'b0, 1'b1);

    // Accept coinciding with a completion
    rdy_mode = 3;
    run_slots(1, 2, 1'b1, 1'b1);
    chk("accept_load_valid", 16'(valid1), 16'h0001);
    chk("accept_load_no_ovr", 16'(ovr1), 16'h0000);
    run_slots(SLOTS - 1, 2, 1'b0, 1'b1);

    // Random frames, occasionally misaligned, random back-pressure
    rdy_mode = 2;
    repeat (10) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 26)) : SLOTS;
      run_slots(n, int'($urandom_range(2, 3)), 1'b1, 1'b1);
    end

    // Reset mid-frame drops the held sample and returns to SEEK
    rdy_mode = 1;
    run_slots(1, 2, 1'b1, 1'b1);
    run_slots(10, 2, 1'b0, 1'b1);
    do_reset();
    rdy_mode = 0;
    run_slots(SLOTS, 2, 1'b0, 1'b0);
    run_slots(SLOTS, 2, 1'b1, 1'b0);
    run_slots(SLOTS, 2, 1'b1, 1'b0);
    run_slots(1, 2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 9'h100, 9'h100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
